// File: rtl/kbd_fifo4.sv
// 4-entry 16-bit key-code FIFO feeding the Hack keyboard register.
// Head entry is read through a 4-way mux on rd_ptr, gated to EMPTY_CODE when empty.

module kbd_mux4 #(
  parameter int W = 16
) (
  input  logic [1:0]        i_sel,
  input  logic [3:0][W-1:0] i_d,
  output logic [W-1:0]      o_q
);
  always_comb begin
    o_q = i_d[0];
    case (i_sel)
      2'd0: o_q = i_d[0];
      2'd1: o_q = i_d[1];
      2'd2: o_q = i_d[2];
      2'd3: o_q = i_d[3];
      default: o_q = i_d[0];
    endcase
  end
endmodule

module kbd_fifo4 #(
  parameter logic [15:0] EMPTY_CODE   = 16'h0000,
  parameter bit          DROP_ON_FULL = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        pop,
  output logic [15:0] kbd_out,
  output logic [2:0]  count,
  output logic        empty,
  output logic        full,
  output logic        overflow,
  input  logic        clr_ovf
);
  logic [3:0][15:0] r_slot;
  logic [1:0]       r_wr_ptr, r_rd_ptr;
  logic [2:0]       r_count;
  logic             r_ovf;

  logic        w_full, w_empty;
  logic        w_push_fire, w_pop_fire, w_write, w_discard;
  logic [15:0] w_head;

  assign w_full  = (r_count == 3'd4);
  assign w_empty = (r_count == 3'd0);

  assign in_ready    = DROP_ON_FULL ? 1'b1 : !w_full;
  assign w_push_fire = in_valid & in_ready;
  assign w_pop_fire  = pop & !w_empty;
  // When full, a same-cycle pop frees the slot the push lands in.
  assign w_write     = w_push_fire & (!w_full | w_pop_fire);
  assign w_discard   = w_push_fire & w_full & !w_pop_fire;

  always_ff @(posedge clk) begin
    if (w_write) r_slot[r_wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      r_count  <= 3'd0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_write)    r_wr_ptr <= r_wr_ptr + 2'd1;
      if (w_pop_fire) r_rd_ptr <= r_rd_ptr + 2'd1;
      case ({w_write, w_pop_fire})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
      // A discard in the same cycle as clr_ovf keeps the flag set.
      if (w_discard)    r_ovf <= 1'b1;
      else if (clr_ovf) r_ovf <= 1'b0;
    end
  end

  kbd_mux4 #(.W(16)) u_rd_mux (
    .i_sel (r_rd_ptr),
    .i_d   (r_slot),
    .o_q   (w_head)
  );

  assign kbd_out  = w_empty ? EMPTY_CODE : w_head;
  assign count    = r_count;
  assign empty    = w_empty;
  assign full     = w_full;
  assign overflow = r_ovf;
endmodule

// File: tb/tb_kbd_fifo4.sv
// Bench for kbd_fifo4: one stall-mode and one drop-mode instance checked
// against a queue-based reference model plus directed scenarios.

module tb_kbd_fifo4;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] a_in_data, b_in_data, a_kbd, b_kbd;
  logic        a_in_valid, b_in_valid, a_pop, b_pop, a_clr, b_clr;
  logic        a_in_ready, b_in_ready, a_empty, b_empty, a_full, b_full, a_ovf, b_ovf;
  logic [2:0]  a_count, b_count;

  kbd_fifo4 #(.EMPTY_CODE(16'h0000), .DROP_ON_FULL(1'b0)) dut_a (
    .clk(clk), .reset_n(reset_n), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .pop(a_pop), .kbd_out(a_kbd), .count(a_count),
    .empty(a_empty), .full(a_full), .overflow(a_ovf), .clr_ovf(a_clr));

  kbd_fifo4 #(.EMPTY_CODE(16'h0000), .DROP_ON_FULL(1'b1)) dut_b (
    .clk(clk), .reset_n(reset_n), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .pop(b_pop), .kbd_out(b_kbd), .count(b_count),
    .empty(b_empty), .full(b_full), .overflow(b_ovf), .clr_ovf(b_clr));

  int checks = 0;
  int passed = 0;

  // Reference model: a queue of stored codes and a sticky overflow bit per instance.
  logic [15:0] mq [2][$];
  bit          mov [2];

  task automatic mstep(input int k, input bit drop, input logic v, input logic [15:0] d,
                       input logic p, input logic c);
    bit was_full, rdy, disc;
    was_full = (mq[k].size() == 4);
    rdy  = drop ? 1'b1 : !was_full;
    disc = 1'b0;
    if (p && mq[k].size() > 0) void'(mq[k].pop_front());
    if (v && rdy) begin
      if (mq[k].size() < 4) mq[k].push_back(d);
      else disc = 1'b1;
    end
    if (c) mov[k] = 1'b0;
    if (disc) mov[k] = 1'b1;
  endtask

  task automatic tick(input logic va, input logic [15:0] da, input logic pa, input logic ca,
                      input logic vb, input logic [15:0] db, input logic pb, input logic cb);
    a_in_valid = va; a_in_data = da; a_pop = pa; a_clr = ca;
    b_in_valid = vb; b_in_data = db; b_pop = pb; b_clr = cb;
    mstep(0, 1'b0, va, da, pa, ca);
    mstep(1, 1'b1, vb, db, pb, cb);
    @(posedge clk); #1;
    a_in_valid = 0; a_pop = 0; a_clr = 0;
    b_in_valid = 0; b_pop = 0; b_clr = 0;
  endtask

  task automatic tick_a(input logic v, input logic [15:0] d, input logic p, input logic c);
    tick(v, d, p, c, 1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic tick_b(input logic v, input logic [15:0] d, input logic p, input logic c);
    tick(1'b0, 16'h0, 1'b0, 1'b0, v, d, p, c);
  endtask

  task automatic test_reset();
    #1;
    checks++; if ({a_kbd, a_empty, a_full, a_in_ready, a_count} !== {16'h0000, 1'b1, 1'b0, 1'b1, 3'd0})
      $display("FAIL reset_hold_a: kbd=%h e=%b f=%b rdy=%b cnt=%0d, want 0000 1 0 1 0", a_kbd, a_empty, a_full, a_in_ready, a_count);
    else passed++;
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    checks++; if ({a_kbd, a_empty, a_count, b_in_ready, b_ovf} !== {16'h0000, 1'b1, 3'd0, 1'b1, 1'b0})
      $display("FAIL reset_idle: kbd=%h e=%b cnt=%0d b_rdy=%b b_ovf=%b, want 0000 1 0 1 0", a_kbd, a_empty, a_count, b_in_ready, b_ovf);
    else passed++;
    tick_a(1, 16'h0007, 0, 0);
    tick_a(1, 16'h0008, 0, 0);
    checks++; if (a_count !== 3'd2) $display("FAIL reset_pre_fill: count=%0d want 2", a_count);
    else passed++;
    #3; reset_n = 1'b0; #1;
    checks++; if ({a_count, a_kbd, a_empty} !== {3'd0, 16'h0000, 1'b1})
      $display("FAIL reset_async: count=%0d kbd=%h empty=%b, want 0 0000 1", a_count, a_kbd, a_empty);
    else passed++;
    mq[0].delete(); mq[1].delete(); mov[0] = 0; mov[1] = 0;
    #2; reset_n = 1'b1;
    @(posedge clk); #1;
    tick_a(1, 16'h0009, 0, 0);
    checks++; if ({a_count, a_kbd} !== {3'd1, 16'h0009})
      $display("FAIL reset_fresh: count=%0d kbd=%h, want 1 0009", a_count, a_kbd);
    else passed++;
    tick_a(0, 16'h0, 1, 0);
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 4; i++) begin
      tick_a(1, 16'h0041 + 16'(i), 0, 0);
      checks++; if (a_count !== 3'(i + 1)) $display("FAIL fill_count: count=%0d want %0d", a_count, i + 1);
      else passed++;
    end
    checks++; if ({a_full, a_in_ready, a_empty} !== 3'b100)
      $display("FAIL fill_full: full=%b rdy=%b empty=%b, want 1 0 0", a_full, a_in_ready, a_empty);
    else passed++;
    tick_a(1, 16'h00EE, 0, 0);
    checks++; if ({a_count, a_kbd} !== {3'd4, 16'h0041})
      $display("FAIL fill_stall: count=%0d kbd=%h, want 4 0041", a_count, a_kbd);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      checks++; if (a_kbd !== 16'h0041 + 16'(i)) $display("FAIL drain_order: kbd=%h want %h", a_kbd, 16'h0041 + 16'(i));
      else passed++;
      tick_a(0, 16'h0, 1, 0);
    end
    checks++; if ({a_kbd, a_empty, a_count} !== {16'h0000, 1'b1, 3'd0})
      $display("FAIL drain_empty: kbd=%h empty=%b count=%0d, want 0000 1 0", a_kbd, a_empty, a_count);
    else passed++;
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 3; i++) tick_a(1, 16'h00C0 + 16'(i), 0, 0);
    for (int i = 0; i < 3; i++) tick_a(0, 16'h0, 1, 0);
    for (int i = 0; i < 4; i++) tick_a(1, 16'h0080 + 16'(i), 0, 0);
    checks++; if (a_count !== 3'd4) $display("FAIL wrap_count: count=%0d want 4", a_count);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      checks++; if (a_kbd !== 16'h0080 + 16'(i)) $display("FAIL wrap_order: kbd=%h want %h", a_kbd, 16'h0080 + 16'(i));
      else passed++;
      tick_a(0, 16'h0, 1, 0);
    end
  endtask

  task automatic test_simul();
    tick_a(1, 16'h0010, 0, 0);
    tick_a(1, 16'h0011, 0, 0);
    tick_a(1, 16'h0020, 1, 0);
    checks++; if ({a_count, a_kbd} !== {3'd2, 16'h0011})
      $display("FAIL simul_mid: count=%0d kbd=%h, want 2 0011", a_count, a_kbd);
    else passed++;
    tick_a(0, 16'h0, 1, 0); tick_a(0, 16'h0, 1, 0);
    tick_a(1, 16'h0031, 1, 0);
    checks++; if ({a_count, a_kbd} !== {3'd1, 16'h0031})
      $display("FAIL simul_empty: count=%0d kbd=%h, want 1 0031", a_count, a_kbd);
    else passed++;
    tick_a(0, 16'h0, 1, 0);
    for (int i = 0; i < 4; i++) tick_b(1, 16'h0050 + 16'(i), 0, 0);
    tick_b(1, 16'h0055, 1, 0);
    checks++; if ({b_count, b_ovf, b_kbd} !== {3'd4, 1'b0, 16'h0051})
      $display("FAIL simul_full: count=%0d ovf=%b kbd=%h, want 4 0 0051", b_count, b_ovf, b_kbd);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      checks++; if (b_kbd !== ((i == 3) ? 16'h0055 : 16'h0051 + 16'(i)))
        $display("FAIL simul_full_order: kbd=%h want %h", b_kbd, (i == 3) ? 16'h0055 : 16'h0051 + 16'(i));
      else passed++;
      tick_b(0, 16'h0, 1, 0);
    end
  endtask

  task automatic test_drop();
    for (int i = 0; i < 4; i++) tick_b(1, 16'h0061 + 16'(i), 0, 0);
    tick_b(1, 16'h0065, 0, 0);
    checks++; if ({b_count, b_ovf, b_in_ready} !== {3'd4, 1'b1, 1'b1})
      $display("FAIL drop_ovf: count=%0d ovf=%b rdy=%b, want 4 1 1", b_count, b_ovf, b_in_ready);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      checks++; if (b_kbd !== 16'h0061 + 16'(i)) $display("FAIL drop_order: kbd=%h want %h", b_kbd, 16'h0061 + 16'(i));
      else passed++;
      tick_b(0, 16'h0, 1, 0);
    end
    checks++; if ({b_empty, b_ovf} !== 2'b11) $display("FAIL drop_sticky: empty=%b ovf=%b, want 1 1", b_empty, b_ovf);
    else passed++;
    tick_b(0, 16'h0, 0, 1);
    checks++; if (b_ovf !== 1'b0) $display("FAIL drop_clr: ovf=%b want 0", b_ovf);
    else passed++;
    for (int i = 0; i < 4; i++) tick_b(1, 16'h0070 + 16'(i), 0, 0);
    tick_b(1, 16'h0077, 0, 1);
    checks++; if ({b_ovf, b_count} !== {1'b1, 3'd4}) $display("FAIL drop_set_wins: ovf=%b count=%0d, want 1 4", b_ovf, b_count);
    else passed++;
    tick_b(0, 16'h0, 0, 1);
    for (int i = 0; i < 4; i++) tick_b(0, 16'h0, 1, 0);
  endtask

  task automatic test_empty_pop();
    for (int i = 0; i < 3; i++) tick_a(0, 16'h0, 1, 0);
    checks++; if ({a_count, a_empty, a_kbd} !== {3'd0, 1'b1, 16'h0000})
      $display("FAIL underflow: count=%0d empty=%b kbd=%h, want 0 1 0000", a_count, a_empty, a_kbd);
    else passed++;
    tick_a(1, 16'h0011, 0, 0);
    checks++; if ({a_count, a_kbd} !== {3'd1, 16'h0011})
      $display("FAIL after_underflow: count=%0d kbd=%h, want 1 0011", a_count, a_kbd);
    else passed++;
    tick_a(0, 16'h0, 1, 0);
  endtask

  task automatic test_random();
    logic [15:0] ea, eb;
    for (int n = 0; n < 400; n++) begin
      tick($urandom_range(0, 2) != 0, 16'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 2) != 0, 16'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
      ea = (mq[0].size() == 0) ? 16'h0000 : mq[0][0];
      eb = (mq[1].size() == 0) ? 16'h0000 : mq[1][0];
      checks++;
      if ({a_kbd, a_count, a_empty, a_full, a_in_ready, a_ovf} !==
          {ea, 3'(mq[0].size()), mq[0].size() == 0, mq[0].size() == 4, mq[0].size() != 4, 1'b0})
        $display("FAIL rand_a[%0d]: kbd=%h cnt=%0d e=%b f=%b rdy=%b ovf=%b, want kbd=%h cnt=%0d",
                 n, a_kbd, a_count, a_empty, a_full, a_in_ready, a_ovf, ea, mq[0].size());
      else passed++;
      checks++;
      if ({b_kbd, b_count, b_empty, b_full, b_in_ready, b_ovf} !==
          {eb, 3'(mq[1].size()), mq[1].size() == 0, mq[1].size() == 4, 1'b1, mov[1]})
        $display("FAIL rand_b[%0d]: kbd=%h cnt=%0d e=%b f=%b rdy=%b ovf=%b, want kbd=%h cnt=%0d ovf=%b",
                 n, b_kbd, b_count, b_empty, b_full, b_in_ready, b_ovf, eb, mq[1].size(), mov[1]);
      else passed++;
    end
  endtask

  initial begin
    a_in_data = 0; a_in_valid = 0; a_pop = 0; a_clr = 0;
    b_in_data = 0; b_in_valid = 0; b_pop = 0; b_clr = 0;
    mov[0] = 0; mov[1] = 0;
    test_reset();
    test_fill_drain();
    test_wrap();
    test_simul();
    test_drop();
    test_empty_pop();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
